alu_op_issue: RTL

//  ID/EX issue stage for the 32-bit MIPS pipeline. Decodes the ID-stage instruction into the 3-bit ALU

---
 rtl/alu_op_issue_pkg.sv | 28 ++
 rtl/alu_op_issue_fwd_mux.sv | 27 ++
 rtl/alu_op_issue.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/alu_op_issue_pkg.sv
// Shared MIPS decode constants: opcode/funct fields, ALU operation codes and
// the immediate-extension helpers used by the ID/EX issue stage.
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_LUI  = 3'b011;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic logic [31:0] zext16(input logic [15:0] imm);
        return {16'h0000, imm};
    endfunction

endpackage

// File: rtl/alu_op_issue_fwd_mux.sv
// Operand bypass: picks the youngest in-flight write-back to the same register,
// falling back to the register-file value. $0 is never bypassed.
module fwd_mux #(
    parameter int DATA_W = 32
) (
    input  logic [4:0]        addr,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              mem_we,
    input  logic [4:0]        mem_wa,
    input  logic [DATA_W-1:0] mem_wd,
    input  logic              wb_we,
    input  logic [4:0]        wb_wa,
    input  logic [DATA_W-1:0] wb_wd,
    output logic [DATA_W-1:0] data
);

    always_comb begin
        data = rf_data;
        if (addr != 5'd0) begin
            if (mem_we && (mem_wa == addr))
                data = mem_wd;
            else if (wb_we && (wb_wa == addr))
                data = wb_wd;
        end
    end

endmodule

// File: rtl/alu_op_issue.sv
// ID/EX issue stage: decodes the ID instruction into ALU control, bypasses
// operands, detects load-use hazards and holds the EX-stage register.
module alu_op_issue
    import mips_defs::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [31:0] id_instr,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic        mem_we,
    input  logic [4:0]  mem_wa,
    input  logic [31:0] mem_wd,
    input  logic        wb_we,
    input  logic [4:0]  wb_wa,
    input  logic [31:0] wb_wd,
    input  logic        flush,
    input  logic        ex_zero,
    output logic        stall_req,
    output logic        ex_valid,
    output logic [31:0] ex_a,
    output logic [31:0] ex_b,
    output logic [2:0]  ex_alu_ctrl,
    output logic [4:0]  ex_wa,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic [31:0] ex_store_data,
    output logic [31:0] ex_pc,
    output logic        ex_branch_taken,
    output logic        ex_illegal
);

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic        is_nop, is_addu, is_subu, is_ori, is_lui, is_lw, is_sw, is_beq;
    logic        legal, live, rs_used, rt_used;
    logic [31:0] rs_fwd, rt_fwd;

    logic [2:0]  alu_ctrl_p0;
    logic [31:0] b_p0;
    logic [4:0]  wa_p0;

    logic        vld_p1, reg_write_p1, mem_read_p1, mem_write_p1, beq_p1, illegal_p1;
    logic [2:0]  alu_ctrl_p1;
    logic [4:0]  wa_p1;
    logic [31:0] a_p1, b_p1, store_p1, pc_p1;

    assign op    = id_instr[31:26];
    assign rs    = id_instr[25:21];
    assign rt    = id_instr[20:16];
    assign rd    = id_instr[15:11];
    assign shamt = id_instr[10:6];
    assign funct = id_instr[5:0];
    assign imm   = id_instr[15:0];

    assign is_nop  = (id_instr == 32'h0);
    assign is_addu = (op == OP_RTYPE) && (funct == FN_ADDU) && (shamt == 5'd0);
    assign is_subu = (op == OP_RTYPE) && (funct == FN_SUBU) && (shamt == 5'd0);
    assign is_ori  = (op == OP_ORI);
    assign is_lui  = (op == OP_LUI);
    assign is_lw   = (op == OP_LW);
    assign is_sw   = (op == OP_SW);
    assign is_beq  = (op == OP_BEQ);
    assign legal   = is_addu | is_subu | is_ori | is_lui | is_lw | is_sw | is_beq;
    assign live    = id_valid & ~is_nop;

    fwd_mux #(.DATA_W(32)) u_fwd_rs (
        .addr(rs), .rf_data(id_rs_data),
        .mem_we(mem_we), .mem_wa(mem_wa), .mem_wd(mem_wd),
        .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
        .data(rs_fwd)
    );

    fwd_mux #(.DATA_W(32)) u_fwd_rt (
        .addr(rt), .rf_data(id_rt_data),
        .mem_we(mem_we), .mem_wa(mem_wa), .mem_wd(mem_wd),
        .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
        .data(rt_fwd)
    );

    // ---- p0: ID-side decode ----
    always_comb begin
        alu_ctrl_p0 = ALU_ADD;
        b_p0        = rt_fwd;
        wa_p0       = 5'd0;
        if (is_subu || is_beq)
            alu_ctrl_p0 = ALU_SUB;
        else if (is_ori)
            alu_ctrl_p0 = ALU_OR;
        else if (is_lui)
            alu_ctrl_p0 = ALU_LUI;
        if (is_ori || is_lui)
            b_p0 = zext16(imm);
        else if (is_lw || is_sw)
            b_p0 = sext16(imm);
        if (live && (is_addu || is_subu))
            wa_p0 = rd;
        else if (live && (is_ori || is_lui || is_lw))
            wa_p0 = rt;
    end

    // lui carries no rs operand; only register-register forms, sw and beq read rt
    assign rs_used   = id_valid & (is_addu | is_subu | is_ori | is_lw | is_sw | is_beq);
    assign rt_used   = id_valid & (is_addu | is_subu | is_sw | is_beq);
    assign stall_req = vld_p1 & mem_read_p1 & (wa_p1 != 5'd0) &
                       ((rs_used & (wa_p1 == rs)) | (rt_used & (wa_p1 == rt)));

    // ---- p1: EX stage register ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset || ((flush || stall_req) && !reset)) begin
            vld_p1       <= 1'b0;
            reg_write_p1 <= 1'b0;
            mem_read_p1  <= 1'b0;
            mem_write_p1 <= 1'b0;
            beq_p1       <= 1'b0;
            illegal_p1   <= 1'b0;
            alu_ctrl_p1  <= 3'b000;
            wa_p1        <= 5'd0;
            a_p1         <= 32'h0;
            b_p1         <= 32'h0;
            store_p1     <= 32'h0;
            pc_p1        <= RESET_PC;
        end else begin
            vld_p1       <= live;
            reg_write_p1 <= live & (is_addu | is_subu | is_ori | is_lui | is_lw);
            mem_read_p1  <= live & is_lw;
            mem_write_p1 <= live & is_sw;
            beq_p1       <= live & is_beq;
            illegal_p1   <= live & ~legal;
            alu_ctrl_p1  <= (live & legal) ? alu_ctrl_p0 : ALU_ADD;
            wa_p1        <= wa_p0;
            a_p1         <= rs_fwd;
            b_p1         <= b_p0;
            store_p1     <= rt_fwd;
            pc_p1        <= id_pc;
        end
    end

    assign ex_valid        = vld_p1;
    assign ex_a            = a_p1;
    assign ex_b            = b_p1;
    assign ex_alu_ctrl     = alu_ctrl_p1;
    assign ex_wa           = wa_p1;
    assign ex_reg_write    = reg_write_p1;
    assign ex_mem_read     = mem_read_p1;
    assign ex_mem_write    = mem_write_p1;
    assign ex_store_data   = store_p1;
    assign ex_pc           = pc_p1;
    assign ex_illegal      = illegal_p1;
    assign ex_branch_taken = vld_p1 & beq_p1 & ex_zero;

endmodule
